adder8_seq_ctrl: RTL and testbench
==================================

Name: adder8_seq_ctrl

Overview:
- Sequencer that time-multiplexes one 8-bit ripple adder (Adder8 datapath) to add operands of 8*BYTES bits.
- Processes one byte per clock, LSB first, with the carry held in a register between bytes.
- Uses a valid/ready handshake on both the operand and result sides.
- Sits between a requester (e.g. an ALU or test driver) and the shared Adder8 instance, trading latency for area.

Parameters:
- BYTES, 4, operand width in bytes (>=1); total width W = 8*BYTES.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand request valid
- in_ready  out  1  block can accept a request
- op_a  in  W  operand A
- op_b  in  W  operand B
- cin  in  1  initial carry-in
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- sum  out  W  result
- cout  out  1  carry out of MSB byte
- ovf  out  1  signed overflow

Behaviour:
- Reset (async, rst_n=0) clears all registers:
  - state=IDLE, in_ready=1 once released
  - out_valid=0, sum=0, cout=0, ovf=0
  - byte index=0, carry register=0
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at a clock edge: latch op_a, op_b; carry_reg<=cin; idx<=0; go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle, Adder8 gets a_reg[8*idx+:8], b_reg[8*idx+:8], carry_reg.
  - At the edge: its Sum goes to sum_reg[8*idx+:8], its Cout goes to carry_reg, idx increments.
  - When idx==BYTES-1 at the edge: go to DONE.
    - cout<=Adder8 Cout.
    - ovf<=(a_msb==b_msb)&&(new sum_msb!=a_msb), where b_msb is the post-inversion value when subtracting.
- DONE:
  - out_valid=1; sum/cout/ovf stable.
  - On out_valid&&out_ready: go to IDLE, out_valid=0.
  - No bypass: in_ready rises the cycle after the result handshake.
- Latency:
  - out_valid rises exactly BYTES clock edges after the accepting edge.
  - Throughput: one operation per BYTES+2 cycles with out_ready tied high.
- Backpressure: with out_ready=0, DONE is held indefinitely and outputs do not change.
- sum updates byte-by-byte during RUN; consumers may sample it only while out_valid=1.
- in_valid while not in IDLE is ignored; op_a/op_b/cin changes after acceptance have no effect.
- BYTES=1: RUN lasts one cycle; carry wrap behaves identically.
- Reset asserted mid-RUN or in DONE: the operation is abandoned immediately and no result is produced.
- Arithmetic is modulo 2^W; cout is the true carry from bit W-1.

Optional Feature:
- Macro: ADDER8_SEQ_SUB_EN.
- Defined:
  - Adds port op_sub (in, 1), latched with the operands.
  - When op_sub=1:
    - Each B byte is inverted before Adder8.
    - Initial carry is forced to 1 and cin is ignored.
    - Result = A-B mod 2^W.
    - cout=1 means no borrow.
    - ovf uses inverted b_msb.
  - When op_sub=0: behaviour is as the base block.
- Undefined: no op_sub port; add only.

Decomposition:
- Shared package adder8_seq_pkg:
  - BYTE_W=8.
  - State enum {IDLE, RUN, DONE}.
  - Function computing index width max(1,$clog2(BYTES)).
- The single natural sub-module is the existing Adder8, instantiated once as the datapath.
- The controller holds only the FSM, operand/result registers, carry register and byte index.

Test Plan (BYTES=4):
- 0x0000_0001+0x0000_0002, cin=0, out_ready=1 -> sum=0x0000_0003, cout=0, ovf=0, out_valid exactly 4 edges after accept.
- 0xFFFF_FFFF+0x0000_0000, cin=1 -> sum=0x0000_0000, cout=1, ovf=0 (carry ripples through all bytes).
- 0x7FFF_FFFF+0x0000_0001 -> sum=0x8000_0000, cout=0, ovf=1; 0x8000_0000+0x8000_0000 -> sum=0, cout=1, ovf=1.
- Hold out_ready=0 for 6 cycles in DONE -> out_valid and sum stable, in_ready=0; in_valid pulses during RUN/DONE are ignored.
- Assert rst_n=0 during the second RUN cycle -> out_valid=0, in_ready=1 after release; the next request 0x10+0x20 returns 0x30.
- With ADDER8_SEQ_SUB_EN: 5-7, op_sub=1 -> sum=0xFFFF_FFFE, cout=0; 7-5 -> sum=0x2, cout=1.

Source files
------------

// File: rtl/adder8_seq_pkg.sv
// Shared definitions for the byte-serial adder sequencer.
//   BYTE_W    : width of the shared adder datapath slice
//   state_t   : sequencer states IDLE / RUN / DONE
//   idx_width : byte-index register width, max(1, clog2(bytes))
package adder8_seq_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic int unsigned idx_width(input int unsigned bytes);
    return (bytes > 1) ? $clog2(bytes) : 1;
  endfunction

endpackage

// File: rtl/adder8_seq_ctrl_adder8.sv
// adder8: 8-bit ripple-carry adder, the shared datapath slice.
// Ports:
//   a, b  in  [7:0]  addends
//   cin   in         carry in
//   sum   out [7:0]  a + b + cin (mod 256)
//   cout  out        carry out of bit 7
module adder8
  import adder8_seq_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              cin,
  output logic [BYTE_W-1:0] sum,
  output logic              cout
);

  logic carry;

  always_comb begin
    sum   = '0;
    carry = cin;
    for (int unsigned i = 0; i < BYTE_W; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/adder8_seq_ctrl.sv
// adder8_seq_ctrl: adds two 8*BYTES-bit operands one byte per clock (LSB
// first) through a single shared adder8, carry held in a register.
// Optional macro ADDER8_SEQ_SUB_EN adds op_sub (A-B mode).
// Ports:
//   clk, rst_n             clock, async active-low reset
//   in_valid / in_ready    operand handshake
//   op_a, op_b, cin        operands and initial carry
//   op_sub                 (ADDER8_SEQ_SUB_EN only) subtract request
//   out_valid / out_ready  result handshake
//   sum, cout, ovf         result, carry out of MSB, signed overflow
module adder8_seq_ctrl
  import adder8_seq_pkg::*;
#(
  parameter int unsigned BYTES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BYTE_W*BYTES-1:0] op_a,
  input  logic [BYTE_W*BYTES-1:0] op_b,
  input  logic                    cin,
`ifdef ADDER8_SEQ_SUB_EN
  input  logic                    op_sub,
`endif
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BYTE_W*BYTES-1:0] sum,
  output logic                    cout,
  output logic                    ovf
);

  localparam int unsigned W    = BYTE_W * BYTES;
  localparam int unsigned IDXW = idx_width(BYTES);
  localparam logic [IDXW-1:0] LAST = IDXW'(BYTES - 1);

  state_t            state;
  logic [W-1:0]      a_reg;
  logic [W-1:0]      b_reg;
  logic              carry_reg;
  logic [IDXW-1:0]   idx;
  logic [BYTE_W-1:0] a_byte;
  logic [BYTE_W-1:0] b_byte;
  logic [BYTE_W-1:0] s_byte;
  logic              c_byte;

  assign a_byte = a_reg[BYTE_W*idx +: BYTE_W];

`ifdef ADDER8_SEQ_SUB_EN
  logic sub_reg;
  // Subtraction is A + ~B + 1; the +1 comes from the forced initial carry.
  assign b_byte = sub_reg ? ~b_reg[BYTE_W*idx +: BYTE_W] : b_reg[BYTE_W*idx +: BYTE_W];
`else
  assign b_byte = b_reg[BYTE_W*idx +: BYTE_W];
`endif

  adder8 u_adder8 (
    .a    (a_byte),
    .b    (b_byte),
    .cin  (carry_reg),
    .sum  (s_byte),
    .cout (c_byte)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      idx       <= '0;
`ifdef ADDER8_SEQ_SUB_EN
      sub_reg   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_reg    <= op_a;
            b_reg    <= op_b;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
`ifdef ADDER8_SEQ_SUB_EN
            sub_reg   <= op_sub;
            carry_reg <= op_sub ? 1'b1 : cin;
`else
            carry_reg <= cin;
`endif
          end
        end
        RUN: begin
          sum[BYTE_W*idx +: BYTE_W] <= s_byte;
          carry_reg                 <= c_byte;
          if (idx == LAST) begin
            // idx parks at 0 so the byte select never leaves a_reg/b_reg.
            idx       <= '0;
            cout      <= c_byte;
            ovf       <= (a_byte[BYTE_W-1] == b_byte[BYTE_W-1]) &&
                         (s_byte[BYTE_W-1] != a_byte[BYTE_W-1]);
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder8_seq_ctrl.sv
module tb_adder8_seq_ctrl;

  localparam int unsigned BYTES = 4;
  localparam int unsigned W     = 8 * BYTES;

  typedef struct packed {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         cin;
`ifdef ADDER8_SEQ_SUB_EN
  logic         op_sub;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int   vectors     = 0;
  int   miscompares = 0;
  exp_t exp_q[$];

  adder8_seq_ctrl #(.BYTES(BYTES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .cin       (cin),
`ifdef ADDER8_SEQ_SUB_EN
    .op_sub    (op_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: whole-word arithmetic on the full operands.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic c, input logic s);
    exp_t       e;
    logic [W:0] full;
    if (s) begin
      e.s  = a - b;
      e.co = (a >= b);
      e.ov = (a[W-1] != b[W-1]) && (e.s[W-1] != a[W-1]);
    end else begin
      full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
      e.s  = full[W-1:0];
      e.co = full[W];
      e.ov = (a[W-1] == b[W-1]) && (e.s[W-1] != a[W-1]);
    end
    return e;
  endfunction

  // Monitor: every result handshake pops one expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("sum", sum, e.s);
          chk("cout", {{(W-1){1'b0}}, cout}, {{(W-1){1'b0}}, e.co});
          chk("ovf", {{(W-1){1'b0}}, ovf}, {{(W-1){1'b0}}, e.ov});
        end
      end
    end
  end

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic s, input int stall);
    int   n;
    exp_t e;
    e = model(a, b, c, s);
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("in_ready_before_op", {{(W-1){1'b0}}, in_ready}, 1);
    op_a      = a;
    op_b      = b;
    cin       = c;
`ifdef ADDER8_SEQ_SUB_EN
    op_sub    = s;
`endif
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    @(posedge clk);
    exp_q.push_back(e);
    #1;
    // Operand changes after acceptance must not matter.
    op_a = $urandom;
    op_b = $urandom;
    cin  = ~c;
`ifdef ADDER8_SEQ_SUB_EN
    op_sub = ~s;
`endif
    chk("in_ready_run", {{(W-1){1'b0}}, in_ready}, 0);
    n = 0;
    do begin
      in_valid = 1'($urandom_range(0, 1));
      @(posedge clk); #1; n++;
    end while (!out_valid && n < 50);
    chk("latency", n, BYTES);
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      chk("hold_valid", {{(W-1){1'b0}}, out_valid}, 1);
      chk("hold_in_ready", {{(W-1){1'b0}}, in_ready}, 0);
      chk("hold_sum", sum, e.s);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("valid_after_hs", {{(W-1){1'b0}}, out_valid}, 0);
    chk("in_ready_after_hs", {{(W-1){1'b0}}, in_ready}, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    cin       = 1'b0;
`ifdef ADDER8_SEQ_SUB_EN
    op_sub    = 1'b0;
`endif
    out_ready = 1'b1;
    #12;
    chk("rst_out_valid", {{(W-1){1'b0}}, out_valid}, 0);
    chk("rst_in_ready", {{(W-1){1'b0}}, in_ready}, 1);
    chk("rst_sum", sum, 0);
    chk("rst_cout", {{(W-1){1'b0}}, cout}, 0);
    chk("rst_ovf", {{(W-1){1'b0}}, ovf}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 0);
    run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 0);
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1);
    run_op(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0, 6);

    // Reset during the second RUN cycle abandons the operation.
    op_a     = 32'hDEAD_BEEF;
    op_b     = 32'h1111_1111;
    cin      = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_valid", {{(W-1){1'b0}}, out_valid}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", {{(W-1){1'b0}}, in_ready}, 1);
    chk("post_rst_valid", {{(W-1){1'b0}}, out_valid}, 0);
    run_op(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, 0);

`ifdef ADDER8_SEQ_SUB_EN
    run_op(32'd5, 32'd7, 1'b0, 1'b1, 0);
    run_op(32'd7, 32'd5, 1'b0, 1'b1, 2);
    run_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 0);
`endif

    for (int k = 0; k < 24; k++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rs;
      ra = $urandom;
      rb = (k % 6 == 0) ? ~ra : W'($urandom);
`ifdef ADDER8_SEQ_SUB_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      run_op(ra, rb, 1'($urandom_range(0, 1)), rs, $urandom_range(0, 3));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
